// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flexible FIFO: default payload type,
// count-width derivation and explicit-compare pointer wrap for any DEPTH.
package fifo_pkg;

  typedef logic [7:0] fifo_data_t;

  // Width needed to hold occupancy values 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_flex_ctrl.sv
// Pointer, occupancy and flag control for fifo_flex. With FIFO_FLEX_BYPASS_EN
// defined, an empty FIFO with a writer and reader both active cuts through.
module fifo_flex_ctrl import fifo_pkg::*; #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned CNT_W    = cnt_w(DEPTH),
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             flush_i,
  input  logic             data_valid_i,
  input  logic             data_ready_i,
  output logic [PTR_W-1:0] w_ptr_o,
  output logic [PTR_W-1:0] r_ptr_o,
  output logic             wr_en_o,
  output logic             bypass_o,
  output logic             data_ready_o,
  output logic             data_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [PTR_W-1:0] r_w_ptr;
  logic [PTR_W-1:0] r_r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef FIFO_FLEX_BYPASS_EN
  assign w_bypass = w_empty & data_valid_i & data_ready_i;
`else
  assign w_bypass = 1'b0;
`endif

  // Handshake: a beat transfers on a side only in a cycle where both its
  // valid and ready are high; bypass beats move input to output untouched.
  assign w_push = data_valid_i & ~w_full & ~w_bypass;
  assign w_pop  = ~w_empty & data_ready_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_w_ptr     <= '0;
      r_r_ptr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      r_w_ptr     <= '0;
      r_r_ptr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_w_ptr <= PTR_W'(ptr_inc(32'(r_w_ptr), DEPTH));
      if (w_pop)  r_r_ptr <= PTR_W'(ptr_inc(32'(r_r_ptr), DEPTH));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (data_valid_i & w_full)               r_overflow  <= 1'b1;
      if (data_ready_i & w_empty & ~w_bypass)  r_underflow <= 1'b1;
    end
  end

  assign w_ptr_o        = r_w_ptr;
  assign r_ptr_o        = r_r_ptr;
  assign wr_en_o        = w_push;
  assign bypass_o       = w_bypass;
  assign data_ready_o   = ~w_full;
  assign data_valid_o   = ~w_empty | w_bypass;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (32'(r_count) >= AFULL_TH);
  assign almost_empty_o = (32'(r_count) <= AEMPTY_TH);
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous first-word-fall-through FIFO of any DEPTH with flush, level
// flags and sticky errors. Optional zero-latency cut-through: FIFO_FLEX_BYPASS_EN.
module fifo_flex import fifo_pkg::*; #(
  parameter int unsigned DEPTH     = 32,
  parameter type         data_t    = fifo_data_t,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             flush_i,
  input  data_t            data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output data_t            data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  data_t            r_mem [DEPTH];
  logic [PTR_W-1:0] w_w_ptr;
  logic [PTR_W-1:0] w_r_ptr;
  logic             w_wr_en;
  logic             w_bypass;

  fifo_flex_ctrl #(
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) u_ctrl (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .flush_i        (flush_i),
    .data_valid_i   (data_valid_i),
    .data_ready_i   (data_ready_i),
    .w_ptr_o        (w_w_ptr),
    .r_ptr_o        (w_r_ptr),
    .wr_en_o        (w_wr_en),
    .bypass_o       (w_bypass),
    .data_ready_o   (data_ready_o),
    .data_valid_o   (data_valid_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  // Storage carries no reset; contents are only observable once counted in.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_w_ptr] <= data_i;
  end

  assign data_o = w_bypass ? data_i : r_mem[w_r_ptr];

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex at DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
// Bypass expectations follow FIFO_FLEX_BYPASS_EN as set for the build.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       arst_ni;
  logic       flush_i;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_flex #(
    .DEPTH     (5),
    .AFULL_TH  (4),
    .AEMPTY_TH (1)
  ) dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .flush_i        (flush_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .data_ready_i   (data_ready_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    data_i       = d;
    data_valid_i = 1'b1;
    data_ready_i = 1'b0;
    tick();
    data_valid_i = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] d);
    data_valid_i = 1'b0;
    data_ready_i = 1'b1;
    #1;
    check("pop_valid", {31'd0, data_valid_o}, 32'd1);
    check("pop_data", {24'd0, data_o}, {24'd0, d});
    tick();
    data_ready_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic check_level(input int c);
    check("lvl_count",  {29'd0, count_o},        32'(c));
    check("lvl_full",   {31'd0, full_o},         (c == 5) ? 32'd1 : 32'd0);
    check("lvl_empty",  {31'd0, empty_o},        (c == 0) ? 32'd1 : 32'd0);
    check("lvl_afull",  {31'd0, almost_full_o},  (c >= 4) ? 32'd1 : 32'd0);
    check("lvl_aempty", {31'd0, almost_empty_o}, (c <= 1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    arst_ni      = 1'b0;
    flush_i      = 1'b0;
    data_i       = 8'h00;
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    #2;
    check("rst_empty",   {31'd0, empty_o},        32'd1);
    check("rst_aempty",  {31'd0, almost_empty_o}, 32'd1);
    check("rst_full",    {31'd0, full_o},         32'd0);
    check("rst_ready",   {31'd0, data_ready_o},   32'd1);
    check("rst_valid",   {31'd0, data_valid_o},   32'd0);
    check("rst_count",   {29'd0, count_o},        32'd0);
    check("rst_ovf",     {31'd0, overflow_o},     32'd0);
    check("rst_unf",     {31'd0, underflow_o},    32'd0);
    @(posedge clk);
    #1;
    arst_ni = 1'b1;

    // Fill to full, then one dropped write.
    for (int k = 0; k < 5; k++) push(8'(8'hA1 + k));
    check("fill_full",  {31'd0, full_o},        32'd1);
    check("fill_count", {29'd0, count_o},       32'd5);
    check("fill_ready", {31'd0, data_ready_o},  32'd0);
    check("fill_head",  {24'd0, data_o},        32'hA1);
    data_i       = 8'hEE;
    data_valid_i = 1'b1;
    tick();
    data_valid_i = 1'b0;
    check("ovf_flag",  {31'd0, overflow_o}, 32'd1);
    check("ovf_count", {29'd0, count_o},    32'd5);
    for (int k = 0; k < 5; k++) pop_expect(8'(8'hA1 + k));
    check("drain_empty", {31'd0, empty_o},     32'd1);
    check("drain_unf",   {31'd0, underflow_o}, 32'd0);

    // Two more full rounds exercise pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) push(8'(8'hA1 + k));
      check("wrap_full", {31'd0, full_o}, 32'd1);
      for (int k = 0; k < 5; k++) pop_expect(8'(8'hA1 + k));
      check("wrap_empty", {31'd0, empty_o}, 32'd1);
    end
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Flush at count 4.
    for (int k = 0; k < 4; k++) push(8'(8'hF0 + k));
    check("pre_flush_count", {29'd0, count_o}, 32'd4);
    do_flush();
    check("flush_count", {29'd0, count_o},      32'd0);
    check("flush_empty", {31'd0, empty_o},      32'd1);
    check("flush_ovf",   {31'd0, overflow_o},   32'd0);
    check("flush_unf",   {31'd0, underflow_o},  32'd0);
    check("flush_valid", {31'd0, data_valid_o}, 32'd0);

    // Level flags stepping 0..5..0.
    for (int c = 0; c < 5; c++) begin
      check_level(c);
      push(8'(8'h10 + c));
    end
    check_level(5);
    for (int c = 5; c > 0; c--) begin
      pop_expect(8'(8'h10 + (5 - c)));
      check_level(c - 1);
    end

    // Simultaneous push and pop at count 3.
    for (int k = 0; k < 4; k++) push(8'(8'hB0 + k));
    pop_expect(8'hB0);
    check("sim_pre_count", {29'd0, count_o}, 32'd3);
    data_i       = 8'h55;
    data_valid_i = 1'b1;
    data_ready_i = 1'b1;
    #1;
    check("sim_head_before", {24'd0, data_o}, 32'hB1);
    tick();
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    check("sim_count", {29'd0, count_o}, 32'd3);
    check("sim_head_after", {24'd0, data_o}, 32'hB2);
    pop_expect(8'hB2);
    pop_expect(8'hB3);
    pop_expect(8'h55);
    check("sim_empty", {31'd0, empty_o}, 32'd1);

    // Full with push and pop requested: only the pop happens.
    for (int k = 0; k < 5; k++) push(8'(8'hC1 + k));
    data_i       = 8'hDD;
    data_valid_i = 1'b1;
    data_ready_i = 1'b1;
    #1;
    check("fpp_ready", {31'd0, data_ready_o}, 32'd0);
    tick();
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    check("fpp_count", {29'd0, count_o},    32'd4);
    check("fpp_head",  {24'd0, data_o},     32'hC2);
    check("fpp_ovf",   {31'd0, overflow_o}, 32'd1);
    do_flush();

    // Read attempt while empty.
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    check("unf_flag", {31'd0, underflow_o}, 32'd1);
    do_flush();
    check("unf_cleared", {31'd0, underflow_o}, 32'd0);

    // Latency from empty: cut-through or one cycle.
    data_i       = 8'h3C;
    data_valid_i = 1'b1;
    data_ready_i = 1'b1;
    #1;
`ifdef FIFO_FLEX_BYPASS_EN
    check("byp_valid", {31'd0, data_valid_o}, 32'd1);
    check("byp_data",  {24'd0, data_o},       32'h3C);
    tick();
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    check("byp_count", {29'd0, count_o},      32'd0);
    check("byp_unf",   {31'd0, underflow_o},  32'd0);
    check("byp_after", {31'd0, data_valid_o}, 32'd0);
`else
    check("lat_valid0", {31'd0, data_valid_o}, 32'd0);
    tick();
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    check("lat_valid1", {31'd0, data_valid_o}, 32'd1);
    check("lat_data",   {24'd0, data_o},       32'h3C);
    check("lat_count",  {29'd0, count_o},      32'd1);
    check("lat_unf",    {31'd0, underflow_o},  32'd1);
    pop_expect(8'h3C);
    check("lat_empty",  {31'd0, empty_o},      32'd1);
`endif
    do_flush();

    // Asynchronous reset between edges during a burst.
    push(8'hD1);
    push(8'hD2);
    data_i       = 8'hD3;
    data_valid_i = 1'b1;
    @(posedge clk);
    #3;
    arst_ni = 1'b0;
    #1;
    check("arst_count", {29'd0, count_o},        32'd0);
    check("arst_empty", {31'd0, empty_o},        32'd1);
    check("arst_aempty", {31'd0, almost_empty_o}, 32'd1);
    check("arst_full",  {31'd0, full_o},         32'd0);
    check("arst_ready", {31'd0, data_ready_o},   32'd1);
    check("arst_valid", {31'd0, data_valid_o},   32'd0);
    data_valid_i = 1'b0;
    #2;
    arst_ni = 1'b1;
    tick();
    push(8'hE1);
    pop_expect(8'hE1);
    check("post_rst_empty", {31'd0, empty_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
